ysyx_22040125_scoreboard: RTL and testbench
===========================================

YSYX_22040125_SCOREBOARD -- requirements
Module: ysyx_22040125_Scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_OUT, default 4, meaning the maximum number of long-latency writes (load/mul/div) in flight, legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 5 each, the decode-stage source register indices.
REQ-005 The block SHALL have ports id_rs1_ren and id_rs2_ren, input, 1 each, which qualify id_rs1 and id_rs2 respectively.
REQ-006 The block SHALL have port id_rd, input, 5, the decode-stage destination index.
REQ-007 The block SHALL have port id_valid, input, 1, meaning a valid instruction is in decode.
REQ-008 The block SHALL have port id_reg_wen, input, 1, meaning the decode instruction writes rd.
REQ-009 The block SHALL have port id_long, input, 1, meaning rd is produced by a long-latency unit.
REQ-010 The block SHALL have ports wb_reg_rd (input, 5) and wb_long_wen (input, 1), meaning a long-latency result for wb_reg_rd is written back this cycle.
REQ-011 The block SHALL have port flush, input, 1, meaning the pipeline is redirected and all long-latency units are aborted this cycle.
REQ-012 The block SHALL have port stall_id, output, 1, which holds decode.
REQ-013 The block SHALL have port pending, output, 32, the registered pending-write bitmap; bit 0 is always 0.
REQ-014 The block SHALL have port out_cnt, output, 3, the number of outstanding long writes.
REQ-015 The block SHALL have port busy, output, 1, equal to (out_cnt != 0).
REQ-016 The block SHALL have port sb_err, output, 1, a sticky protocol-error flag.

Function
REQ-017 The block SHALL define eff_pending as pending with bit wb_reg_rd cleared when wb_long_wen=1, so that a same-cycle writeback is bypassed and the forwarding path supplies the data.
REQ-018 The block SHALL define raw_hit as (id_rs1_ren && id_rs1!=0 && eff_pending[id_rs1]) || (id_rs2_ren && id_rs2!=0 && eff_pending[id_rs2]).
REQ-019 The block SHALL define waw_hit as id_reg_wen && id_rd!=0 && eff_pending[id_rd], and it SHALL apply to both long and non-long writers.
REQ-020 The block SHALL define full_hit as id_reg_wen && id_long && id_rd!=0 && (out_cnt - (wb_long_wen && out_cnt!=0)) == MAX_OUT.
REQ-021 The block SHALL drive stall_id combinationally as id_valid && !flush && (raw_hit || waw_hit || full_hit).
REQ-022 The block SHALL define issue as id_valid && !stall_id && !flush && id_reg_wen && id_long && id_rd!=0; rd=0 never sets a bit and never counts.
REQ-023 On issue, the block SHALL set pending[id_rd] at the next edge.
REQ-024 On wb_long_wen with wb_reg_rd!=0, the block SHALL clear pending[wb_reg_rd].
REQ-025 When a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-026 The block SHALL update out_cnt as +1 on issue only, -1 on a legal retire only, and unchanged when both occur.
REQ-027 A legal retire SHALL be wb_long_wen && out_cnt!=0.
REQ-028 The block SHALL have no saturation wrap: out_cnt never exceeds MAX_OUT because full_hit blocks issue.
REQ-029 The block SHALL set sb_err and hold it until rst when wb_long_wen occurs with out_cnt==0.
REQ-030 The block SHALL set sb_err and hold it until rst when wb_long_wen occurs with wb_reg_rd!=0 and pending[wb_reg_rd]==0.
REQ-031 On an illegal retire, the block SHALL leave the counter unchanged.
REQ-032 On flush, the block SHALL clear pending and out_cnt to 0 at the next edge, overriding same-cycle issue and retire.
REQ-033 During flush, stall_id SHALL be 0.
REQ-034 The block SHALL have zero-cycle latency from inputs to stall_id and one-cycle latency from issue or retire to pending and out_cnt.

Reset
REQ-035 When rst=1 at a clock edge, the block SHALL set pending=0, out_cnt=0, busy=0 and sb_err=0; rst has priority over flush, issue and retire.
REQ-036 stall_id SHALL stay combinational during reset; the pipeline ignores it while rst=1.
REQ-037 Reset asserted mid-operation SHALL discard all outstanding state; late writebacks arriving after reset SHALL set sb_err.

Verification
REQ-038 The bench SHALL cover load-use: issue long rd=5; next cycle id_rs1=5 with ren set -> stall_id=1 and pending[5]=1; wb_long_wen with rd=5 -> stall_id=0 in that same cycle; pending[5]=0 next cycle.
REQ-039 The bench SHALL cover full: MAX_OUT=4 with long issues to x1..x4 -> out_cnt=4; a 5th long issue to x6 -> stall_id=1; the same cycle with wb_long_wen for x1 -> issue accepted, out_cnt stays 4, pending bits {2,3,4,6} set.
REQ-040 The bench SHALL cover x0 and WAW: a long issue to rd=0 -> no stall, pending=0, out_cnt=0; pending[7]=1 and a non-long write to rd=7 -> stall_id=1.
REQ-041 The bench SHALL cover same-bit set/clear: pending[9]=1 with wb_long_wen rd=9 and a simultaneous long issue rd=9 -> no stall, pending[9]=1, out_cnt unchanged.
REQ-042 The bench SHALL cover flush: with out_cnt=3, flush plus a same-cycle long issue -> next cycle pending=0, out_cnt=0, busy=0.
REQ-043 The bench SHALL cover errors: wb_long_wen with out_cnt=0 -> sb_err=1 persisting through flush; rst clears it to 0.

Source files
------------

// File: rtl/ysyx_22040125_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_22040125_scoreboard
//
// Register scoreboard for long-latency writers (load / mul / div). It tracks
// which architectural registers still wait on an outstanding long result.
// It also stalls decode on RAW, WAW and in-flight-capacity hazards, and it
// flags writebacks that have no matching issue.
//
// Ports
//   clk, rst                  single clock; synchronous active-high reset
//   id_rs1/id_rs2 (+_ren)     decode source indices and their read enables
//   id_rd, id_valid,          decode destination, instruction-valid,
//   id_reg_wen, id_long       writes-rd flag, long-latency-producer flag
//   wb_reg_rd, wb_long_wen    long-latency writeback this cycle
//   flush                     pipeline redirect; aborts all long units
//   stall_id                  combinational decode hold
//   pending                   registered pending-write bitmap (bit 0 = 0)
//   out_cnt, busy             outstanding long writes, and (out_cnt != 0)
//   sb_err                    sticky protocol-error flag, cleared by rst
// ---------------------------------------------------------------------------
module ysyx_22040125_scoreboard #(
  parameter int MAX_OUT = 4  // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_ren,
  input  logic        id_rs2_ren,
  input  logic [4:0]  id_rd,
  input  logic        id_valid,
  input  logic        id_reg_wen,
  input  logic        id_long,
  input  logic [4:0]  wb_reg_rd,
  input  logic        wb_long_wen,
  input  logic        flush,
  output logic        stall_id,
  output logic [31:0] pending,
  output logic [2:0]  out_cnt,
  output logic        busy,
  output logic        sb_err
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUT);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic        sb_err_q,  sb_err_d;

  logic [31:0] eff_pending;
  logic [31:0] wb_mask;
  logic        legal_retire;
  logic [2:0]  cnt_after_retire;
  logic        raw_hit, waw_hit, full_hit;
  logic        issue;

  // Hazard detection. A writeback landing this cycle is treated as already
  // retired, because the forwarding path supplies its data to decode.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so
    // that no path through the block leaves it unassigned and infers a latch.
    wb_mask = '0;
    if (wb_long_wen) wb_mask[wb_reg_rd] = 1'b1;
    eff_pending = pending_q & ~wb_mask;

    legal_retire     = wb_long_wen && (out_cnt_q != 3'd0);
    cnt_after_retire = out_cnt_q - {2'b00, legal_retire};

    raw_hit  = (id_rs1_ren && (id_rs1 != 5'd0) && eff_pending[id_rs1]) ||
               (id_rs2_ren && (id_rs2 != 5'd0) && eff_pending[id_rs2]);
    waw_hit  = id_reg_wen && (id_rd != 5'd0) && eff_pending[id_rd];
    full_hit = id_reg_wen && id_long && (id_rd != 5'd0) &&
               (cnt_after_retire == MaxOut);

    stall_id = id_valid && !flush && (raw_hit || waw_hit || full_hit);
    issue    = id_valid && !stall_id && !flush && id_reg_wen && id_long &&
               (id_rd != 5'd0);
  end

  // Next-state logic for the bitmap, the counter and the error flag.
  always_comb begin
    pending_d = pending_q;
    out_cnt_d = out_cnt_q;
    sb_err_d  = sb_err_q;

    // The clear is applied first so that a same-cycle set of the same bit wins.
    if (wb_long_wen && (wb_reg_rd != 5'd0)) pending_d[wb_reg_rd] = 1'b0;
    if (issue)                              pending_d[id_rd]     = 1'b1;
    pending_d[0] = 1'b0;

    // Simultaneous issue and retire leave the count unchanged.
    // An illegal retire (out_cnt==0) never decrements.
    unique case ({issue, legal_retire})
      2'b10:   out_cnt_d = out_cnt_q + 3'd1;
      2'b01:   out_cnt_d = out_cnt_q - 3'd1;
      default: out_cnt_d = out_cnt_q;
    endcase

    if (flush) begin
      pending_d = '0;
      out_cnt_d = '0;
    end

    // The error flag is sticky across flush; only rst clears it.
    if (wb_long_wen && (out_cnt_q == 3'd0))                          sb_err_d = 1'b1;
    if (wb_long_wen && (wb_reg_rd != 5'd0) && !pending_q[wb_reg_rd]) sb_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pending_q <= '0;
      out_cnt_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_cnt_q <= out_cnt_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign pending = pending_q;
  assign out_cnt = out_cnt_q;
  assign busy    = (out_cnt_q != 3'd0);
  assign sb_err  = sb_err_q;

endmodule

// File: tb/tb_ysyx_22040125_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040125_scoreboard
//
// Directed bench for the register scoreboard (MAX_OUT = 4). Inputs change
// 1 ns after a rising edge. Combinational outputs are sampled 1 ns later,
// and registered outputs are sampled 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22040125_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_reg_rd;
  logic        id_rs1_ren, id_rs2_ren, id_valid, id_reg_wen, id_long;
  logic        wb_long_wen, flush;
  logic        stall_id, busy, sb_err;
  logic [31:0] pending;
  logic [2:0]  out_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22040125_scoreboard #(.MAX_OUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_ren (id_rs1_ren),
    .id_rs2_ren (id_rs2_ren),
    .id_rd      (id_rd),
    .id_valid   (id_valid),
    .id_reg_wen (id_reg_wen),
    .id_long    (id_long),
    .wb_reg_rd  (wb_reg_rd),
    .wb_long_wen(wb_long_wen),
    .flush      (flush),
    .stall_id   (stall_id),
    .pending    (pending),
    .out_cnt    (out_cnt),
    .busy       (busy),
    .sb_err     (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_ren = 1'b0; id_rs2_ren = 1'b0;
    id_rd = '0; id_valid = 1'b0; id_reg_wen = 1'b0; id_long = 1'b0;
    wb_reg_rd = '0; wb_long_wen = 1'b0; flush = 1'b0;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    id_valid = 1'b1; id_reg_wen = 1'b1; id_long = 1'b1; id_rd = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();

    // Reset state
    #1;
    check("rst_pending", pending, 32'h0);
    check("rst_out_cnt", {29'd0, out_cnt}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_sb_err",  {31'd0, sb_err},  32'd0);
    check("rst_stall",   {31'd0, stall_id}, 32'd0);

    // Load-use: long write to x5, then read x5
    long_issue(5'd5);
    #1 check("lu_issue_stall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_ren = 1'b1;
    #1;
    check("lu_raw_stall",  {31'd0, stall_id}, 32'd1);
    check("lu_pending5",   {31'd0, pending[5]}, 32'd1);
    check("lu_out_cnt",    {29'd0, out_cnt}, 32'd1);
    wb_long_wen = 1'b1; wb_reg_rd = 5'd5;
    #1 check("lu_bypass_stall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    #1;
    check("lu_pending_clr", pending, 32'h0);
    check("lu_cnt_zero",    {29'd0, out_cnt}, 32'd0);
    check("lu_busy_zero",   {31'd0, busy},    32'd0);

    // Full: fill x1..x4
    for (int r = 1; r <= 4; r++) begin
      long_issue(5'(r));
      tick();
    end
    idle();
    #1;
    check("full_cnt4",    {29'd0, out_cnt}, 32'd4);
    check("full_pending", pending, 32'h0000_001E);
    long_issue(5'd6);
    #1 check("full_stall", {31'd0, stall_id}, 32'd1);
    wb_long_wen = 1'b1; wb_reg_rd = 5'd1;
    #1 check("full_retire_unstall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    #1;
    check("full_cnt_stays4", {29'd0, out_cnt}, 32'd4);
    check("full_pending2",   pending, 32'h0000_005C);
    check("full_no_err",     {31'd0, sb_err}, 32'd0);

    // Drain with a flush
    flush = 1'b1;
    tick();
    idle();
    #1 check("drain_cnt", {29'd0, out_cnt}, 32'd0);

    // x0 is never tracked
    long_issue(5'd0);
    #1 check("x0_stall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    #1;
    check("x0_pending", pending, 32'h0);
    check("x0_cnt",     {29'd0, out_cnt}, 32'd0);

    // WAW: a short writer to a pending register stalls
    long_issue(5'd7);
    tick();
    idle();
    #1 check("waw_pending7", pending, 32'h0000_0080);
    id_valid = 1'b1; id_reg_wen = 1'b1; id_long = 1'b0; id_rd = 5'd7;
    #1 check("waw_stall", {31'd0, stall_id}, 32'd1);
    idle();

    // Same-bit set/clear: set wins
    long_issue(5'd9);
    tick();
    idle();
    #1 check("sb_pre_cnt", {29'd0, out_cnt}, 32'd2);
    long_issue(5'd9);
    wb_long_wen = 1'b1; wb_reg_rd = 5'd9;
    #1 check("sb_stall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    #1;
    check("sb_pending", pending, 32'h0000_0280);
    check("sb_cnt",     {29'd0, out_cnt}, 32'd2);

    // Flush with out_cnt=3 and a same-cycle issue
    long_issue(5'd10);
    tick();
    idle();
    #1 check("fl_pre_cnt", {29'd0, out_cnt}, 32'd3);
    long_issue(5'd11);
    id_rs1 = 5'd10; id_rs1_ren = 1'b1;
    flush = 1'b1;
    #1 check("fl_stall", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    #1;
    check("fl_pending", pending, 32'h0);
    check("fl_cnt",     {29'd0, out_cnt}, 32'd0);
    check("fl_busy",    {31'd0, busy},    32'd0);

    // Error: writeback with nothing outstanding
    wb_long_wen = 1'b1; wb_reg_rd = 5'd3;
    tick();
    idle();
    #1;
    check("err_set",     {31'd0, sb_err},  32'd1);
    check("err_cnt",     {29'd0, out_cnt}, 32'd0);
    flush = 1'b1;
    tick();
    idle();
    #1 check("err_sticky_flush", {31'd0, sb_err}, 32'd1);
    do_reset();
    #1 check("err_rst_clear", {31'd0, sb_err}, 32'd0);

    // Late writeback after a mid-operation reset
    long_issue(5'd12);
    tick();
    idle();
    do_reset();
    #1 check("late_rst_pending", pending, 32'h0);
    wb_long_wen = 1'b1; wb_reg_rd = 5'd12;
    tick();
    idle();
    #1 check("late_wb_err", {31'd0, sb_err}, 32'd1);
    do_reset();

    // Writeback to a non-pending register while count is nonzero
    long_issue(5'd13);
    tick();
    idle();
    wb_long_wen = 1'b1; wb_reg_rd = 5'd14;
    tick();
    idle();
    #1;
    check("miss_err",     {31'd0, sb_err},  32'd1);
    check("miss_cnt",     {29'd0, out_cnt}, 32'd0);
    check("miss_pending", pending, 32'h0000_2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
